// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore control FSM for the multicycle RV32I datapath.
// It steps each instruction through fetch, decode, execute, memory and
// writeback. It drives every enable and mux select of the external datapath
// and of the shared memory port.
// Outputs are decoded combinationally from the state register and the wait
// counter. During reset they therefore already show the FETCH decode.
// Optional feature: define CTRL_HALT_ECALL_EN to make ECALL (Funct3=000)
// enter an absorbing HALT state. When it is undefined, SYSTEM opcodes
// behave as NOPs.
//
// state   | meaning
// FETCH   | read instruction at PC, load IR/PCBack and PC+4 on last cycle
// DECODE  | decode opcode, precompute branch/JAL target into SaidaULA
// EXEC_R  | register-register ALU operation
// EXEC_I  | register-immediate ALU operation
// ENDER   | load/store address calculation
// LE_MEM  | data memory read
// ESC_MEM | data memory write (write strobe on first cycle only)
// WB_ULA  | write ALU result to register file
// WB_MEM  | write loaded data to register file
// BRANCH  | compare rs1/rs2, conditional PC load from SaidaULA
// JAL     | PC <- SaidaULA, rd <- PC
// JALR    | PC <- (rs1+imm)&~1, rd <- PC
// LUI     | rd <- 0 + imm
// AUIPC   | rd <- PCBack + imm
// ILEGAL  | unknown opcode, exception raised until reset
// HALT    | ECALL stop until reset (only with CTRL_HALT_ECALL_EN)

module controle_multiciclo #(
  parameter int LAT_MEM = 1
) (
  input  logic       clockCPU,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  output logic       EscrevePC,
  output logic       EscrevePCB,
  output logic [1:0] OrigPC,
  output logic       EscreveIR,
  output logic       IouD,
  output logic       LeMem,
  output logic       EscreveMem,
  output logic       EscreveReg,
  output logic [1:0] Mem2Reg,
  output logic [1:0] OrigAULA,
  output logic [1:0] OrigBULA,
  output logic [1:0] ALUOp,
  output logic [3:0] Estado,
  output logic       Excecao
);

  localparam int CW = (LAT_MEM < 2) ? 1 : $clog2(LAT_MEM + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT_MEM - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ENDER   = 4'd4,
    S_LE_MEM  = 4'd5,
    S_ESC_MEM = 4'd6,
    S_WB_ULA  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_LUI     = 4'd12,
    S_AUIPC   = 4'd13,
    S_ILEGAL  = 4'd14,
    S_HALT    = 4'd15
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last, cnt_first;

  assign cnt_last  = (cnt_q == CNT_LAST);
  assign cnt_first = (cnt_q == '0);
  assign Estado    = state_q;

  // State and wait-counter registers; async reset drops any in-flight access.
  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode; memory states hold until the counter reaches LAT_MEM-1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (cnt_last) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_R:      state_d = S_EXEC_R;
          OP_I:      state_d = S_EXEC_I;
          OP_LOAD:   state_d = S_ENDER;
          OP_STORE:  state_d = S_ENDER;
          // SLT-style funct3 values are not valid branches; trap before any PC write.
          OP_BRANCH: state_d = (Funct3 == 3'b010 || Funct3 == 3'b011) ? S_ILEGAL : S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
`ifdef CTRL_HALT_ECALL_EN
          OP_SYSTEM: state_d = (Funct3 == 3'b000) ? S_HALT : S_FETCH;
`else
          OP_SYSTEM: state_d = S_FETCH;
`endif
          default:   state_d = S_ILEGAL;
        endcase
      end
      S_EXEC_R:  state_d = S_WB_ULA;
      S_EXEC_I:  state_d = S_WB_ULA;
      S_ENDER:   state_d = (Opcode == OP_LOAD) ? S_LE_MEM : S_ESC_MEM;
      S_LE_MEM:  if (cnt_last) state_d = S_WB_MEM;
      S_ESC_MEM: if (cnt_last) state_d = S_FETCH;
      S_WB_ULA:  state_d = S_FETCH;
      S_WB_MEM:  state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JAL:     state_d = S_FETCH;
      S_JALR:    state_d = S_FETCH;
      S_LUI:     state_d = S_FETCH;
      S_AUIPC:   state_d = S_FETCH;
      S_ILEGAL:  state_d = S_ILEGAL;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_ILEGAL;
    endcase
  end

  // Wait counter: restarts on each state change and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (!cnt_last)     cnt_d = cnt_q + CW'(1);
  end

  // Moore output decode; every output not named in a state stays 0.
  always_comb begin
    EscrevePC  = 1'b0;
    EscrevePCB = 1'b0;
    OrigPC     = 2'd0;
    EscreveIR  = 1'b0;
    IouD       = 1'b0;
    LeMem      = 1'b0;
    EscreveMem = 1'b0;
    EscreveReg = 1'b0;
    Mem2Reg    = 2'd0;
    OrigAULA   = 2'd0;
    OrigBULA   = 2'd0;
    ALUOp      = 2'd0;
    Excecao    = 1'b0;
    case (state_q)
      S_FETCH: begin
        LeMem     = 1'b1;
        OrigAULA  = 2'd2;
        OrigBULA  = 2'd1;
        EscreveIR = cnt_last;
        EscrevePC = cnt_last;
      end
      S_DECODE: begin
        OrigAULA = 2'd0;
        OrigBULA = 2'd2;
      end
      S_EXEC_R: begin
        OrigAULA = 2'd1;
        OrigBULA = 2'd0;
        ALUOp    = 2'd2;
      end
      S_EXEC_I: begin
        OrigAULA = 2'd1;
        OrigBULA = 2'd2;
        ALUOp    = 2'd2;
      end
      S_ENDER: begin
        OrigAULA = 2'd1;
        OrigBULA = 2'd2;
      end
      S_LE_MEM: begin
        IouD  = 1'b1;
        LeMem = 1'b1;
      end
      S_ESC_MEM: begin
        IouD       = 1'b1;
        EscreveMem = cnt_first;
      end
      S_WB_ULA: begin
        EscreveReg = 1'b1;
      end
      S_WB_MEM: begin
        EscreveReg = 1'b1;
        Mem2Reg    = 2'd1;
      end
      S_BRANCH: begin
        OrigAULA   = 2'd1;
        OrigBULA   = 2'd0;
        ALUOp      = 2'd1;
        EscrevePCB = 1'b1;
        OrigPC     = 2'd1;
      end
      S_JAL: begin
        EscrevePC  = 1'b1;
        OrigPC     = 2'd1;
        EscreveReg = 1'b1;
        Mem2Reg    = 2'd2;
      end
      S_JALR: begin
        OrigAULA   = 2'd1;
        OrigBULA   = 2'd2;
        EscrevePC  = 1'b1;
        OrigPC     = 2'd2;
        EscreveReg = 1'b1;
        Mem2Reg    = 2'd2;
      end
      S_LUI: begin
        OrigAULA   = 2'd3;
        OrigBULA   = 2'd2;
        EscreveReg = 1'b1;
      end
      S_AUIPC: begin
        OrigAULA   = 2'd0;
        OrigBULA   = 2'd2;
        EscreveReg = 1'b1;
      end
      S_ILEGAL: begin
        Excecao = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
